cmp_share_arbiter: RTL and testbench
====================================

# cmp_share_arbiter

Round-robin arbiter and sequencer that shares one N-bit magnitude comparator among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, drives the shared comparator, and returns the registered lesser/greater/equal result tagged with the requester index. It sits between the requesting datapaths and the single comparator instance, which is instantiated inside this block.

## Interface
- WIDTH, 8, operand width in bits (1..32)
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of the requester index (localparam)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  bit i: requester i presents an operand pair
- req_ready  output  NREQ  bit i: pair i is accepted this cycle (one-hot or zero)
- req_a  input  NREQ*WIDTH  operand a of requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand b of requester i, same packing
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_lesser  output  1  a < b
- rsp_greater  output  1  a > b
- rsp_equal  output  1  a == b

## Operation
- Result register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- Issue condition: `can_issue = !rsp_valid || rsp_ready`.
- Arbitration when can_issue:
  - Search req_valid starting at index ptr and wrapping modulo NREQ.
  - The first set bit g wins; req_ready[g]=1, all other bits 0.
  - req_ready is combinational from req_valid, ptr and rsp_valid/rsp_ready.
- Arbitration when can_issue=0: req_ready is all zero.
- On a grant g, at the clock edge:
  - req_a[g] and req_b[g] feed the shared comparator combinationally.
  - The three flags and rsp_id=g are registered; rsp_valid becomes 1.
  - ptr becomes (g+1) mod NREQ.
- No grant: ptr holds.
- Result consumed with no new grant (rsp_valid && rsp_ready): rsp_valid becomes 0.
- Consume and grant in the same cycle: the register reloads and rsp_valid stays 1.
- Output flags are always exactly one-hot while rsp_valid=1.
- Output flags hold their last value while rsp_valid=0 (don't-care for checkers).
- Requesters must hold req_a/req_b stable while req_valid is high and not yet granted. The block does not check this.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_lesser=0, rsp_greater=0, rsp_equal=0, ptr=0.
- While rst_n=0, req_ready=0.
- Latency: grant edge to rsp_valid = 1 cycle.
- Throughput: 1 result per cycle while rsp_ready=1.
- Backpressure: with rsp_valid=1 and rsp_ready=0, rsp_* outputs are stable and no grant is issued.
- Fairness: a continuously valid requester is granted within NREQ issue opportunities.
- Reset asserted mid-operation:
  - Any held result is discarded immediately (asynchronous) and ptr returns to 0.
  - The first grant after release goes to the lowest-index valid requester.
- No req_valid bits set: no grant. An EMPTY register stays EMPTY.

## Configuration
- CMP_SIGNED_EN defined: operands are compared as WIDTH-bit two's-complement signed values.
- CMP_SIGNED_EN undefined (default): operands are compared as unsigned.
- Arbitration and handshake are identical in both builds.

## Test plan
- Single request, requester 0, a=111, b=250, rsp_ready=1: req_ready=4'b0001 for 1 cycle; next cycle rsp_valid=1, rsp_id=0, lesser=1, greater=0, equal=0.
- All four requesters valid after reset with pairs (147,103), (255,255), (85,25), (21,50), rsp_ready=1: grant order 0,1,2,3 on consecutive cycles; results in order are greater, equal, greater, lesser with ids 0..3.
- Backpressure: result (199,220) from requester 2 held with rsp_ready=0 for 3 cycles while requesters 0 and 3 are valid:
  - req_ready=0 and rsp_* stable throughout.
  - On rsp_ready=1, requester 3 is granted (ptr=3) in the same cycle as the consume.
- Rotation fairness: requesters 1 and 2 continuously valid with (96,96) and (79,74): grants alternate 1,2,1,2.
- Reset mid-operation: rst_n pulsed low while rsp_valid=1 → rsp_valid=0 immediately; after release with requesters 2 and 3 valid, requester 2 is granted first.
- CMP_SIGNED_EN build, a=8'h80, b=8'h01: rsp_lesser=1. Default build with the same operands: rsp_greater=1.

Source files
------------

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one magnitude comparator among NREQ requesters (CMP_SIGNED_EN selects signed compare)
module cmp_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_lesser,
  output logic                  rsp_greater,
  output logic                  rsp_equal
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, w_gid;
  logic w_found, w_can_issue, w_grant, w_lt, w_eq;
  logic [WIDTH-1:0] w_a, w_b;
  // first valid requester at or after r_ptr, wrapping modulo NREQ
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_gid = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_gid = IDW'(j);
      end
    end
  end
  assign w_can_issue = !rsp_valid || rsp_ready;
  assign w_grant = rst_n && w_can_issue && w_found;
  assign req_ready = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gid) : '0;
  assign w_a = req_a[w_gid*WIDTH +: WIDTH];
  assign w_b = req_b[w_gid*WIDTH +: WIDTH];
`ifdef CMP_SIGNED_EN
  assign w_lt = $signed(w_a) < $signed(w_b);
`else
  assign w_lt = w_a < w_b;
`endif
  assign w_eq = w_a == w_b;
  assign rsp_valid = r_state == FULL;
  // result register occupancy: a grant fills it, a consume without grant empties it
  always_comb begin
    w_next = r_state;
    if (w_grant) w_next = FULL;
    else if (rsp_ready) w_next = EMPTY;
  end
  // occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  end
  // capture comparator result and advance the round-robin pointer on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id <= '0;
      rsp_lesser <= 1'b0;
      rsp_greater <= 1'b0;
      rsp_equal <= 1'b0;
      r_ptr <= '0;
    end else if (w_grant) begin
      rsp_id <= w_gid;
      rsp_lesser <= w_lt;
      rsp_greater <= !w_lt && !w_eq;
      rsp_equal <= w_eq;
      r_ptr <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
    end
  end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed scoreboard bench for cmp_share_arbiter
module tb_cmp_share_arbiter;
  logic clk, rst_n, rsp_valid, rsp_ready, rsp_lesser, rsp_greater, rsp_equal;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0] rsp_id;
  logic [4:0] q[$];
  logic [4:0] last;
  logic m_valid;
  int checks, errors;

  cmp_share_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_lesser(rsp_lesser), .rsp_greater(rsp_greater), .rsp_equal(rsp_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
    logic lt, eq;
`ifdef CMP_SIGNED_EN
    lt = $signed(a) < $signed(b);
`else
    lt = a < b;
`endif
    eq = a == b;
    return {lt, !lt && !eq, eq};
  endfunction

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic chk(input logic [4:0] got, input logic [4:0] want, input string tag);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] er, input string tag);
    int g;
    req_valid = v;
    rsp_ready = rr;
    #1;
    chk({1'b0, req_ready}, {1'b0, er}, {tag, "_ready"});
    if (er != 4'b0) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (er[i]) g = i;
      q.push_back({2'(g), ref_cmp(req_a[g*8 +: 8], req_b[g*8 +: 8])});
      m_valid = 1'b1;
    end else if (rr) m_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({4'b0, rsp_valid}, {4'b0, m_valid}, {tag, "_valid"});
    if (er != 4'b0) begin
      if (q.size() > 0) last = q.pop_front();
      chk({rsp_id, rsp_lesser, rsp_greater, rsp_equal}, last, {tag, "_rsp"});
    end else if (m_valid) chk({rsp_id, rsp_lesser, rsp_greater, rsp_equal}, last, {tag, "_hold"});
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({4'b0, rsp_valid}, 5'b0, {tag, "_rst_valid"});
    chk({1'b0, req_ready}, 5'b0, {tag, "_rst_ready"});
    #2;
    rst_n = 1'b1;
    m_valid = 1'b0;
    q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_valid = 1'b0;
    last = '0;
    rst_n = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    #2;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk({4'b0, rsp_valid}, 5'b0, "reset_valid");
    chk({rsp_id, rsp_lesser, rsp_greater, rsp_equal}, 5'b0, "reset_rsp");
    chk({1'b0, req_ready}, 5'b0, "reset_ready");
    #9;
    rst_n = 1'b1;
    req_valid = 4'b0;
    set_op(0, 8'd111, 8'd250);
    step(4'b0001, 1'b1, 4'b0001, "single");
    step(4'b0000, 1'b1, 4'b0000, "drain1");
    do_reset("pre_all");
    set_op(0, 8'd147, 8'd103);
    set_op(1, 8'd255, 8'd255);
    set_op(2, 8'd85, 8'd25);
    set_op(3, 8'd21, 8'd50);
    step(4'b1111, 1'b1, 4'b0001, "all0");
    step(4'b1110, 1'b1, 4'b0010, "all1");
    step(4'b1100, 1'b1, 4'b0100, "all2");
    step(4'b1000, 1'b1, 4'b1000, "all3");
    step(4'b0000, 1'b1, 4'b0000, "drain2");
    set_op(2, 8'd199, 8'd220);
    set_op(3, 8'd10, 8'd10);
    set_op(0, 8'd111, 8'd250);
    step(4'b0100, 1'b0, 4'b0100, "bp_load");
    step(4'b1001, 1'b0, 4'b0000, "bp_hold1");
    step(4'b1001, 1'b0, 4'b0000, "bp_hold2");
    step(4'b1001, 1'b0, 4'b0000, "bp_hold3");
    step(4'b1001, 1'b1, 4'b1000, "bp_release");
    step(4'b0001, 1'b1, 4'b0001, "bp_next");
    step(4'b0000, 1'b1, 4'b0000, "drain3");
    set_op(1, 8'd96, 8'd96);
    set_op(2, 8'd79, 8'd74);
    step(4'b0110, 1'b1, 4'b0010, "rr1a");
    step(4'b0110, 1'b1, 4'b0100, "rr2a");
    step(4'b0110, 1'b1, 4'b0010, "rr1b");
    step(4'b0110, 1'b1, 4'b0100, "rr2b");
    req_valid = 4'b0110;
    do_reset("mid");
    step(4'b1100, 1'b1, 4'b0100, "post_rst2");
    step(4'b1000, 1'b1, 4'b1000, "post_rst3");
    set_op(0, 8'h80, 8'h01);
    step(4'b0001, 1'b1, 4'b0001, "sign");
`ifdef CMP_SIGNED_EN
    chk({2'b0, rsp_lesser, rsp_greater, rsp_equal}, 5'b00100, "sign_mode");
`else
    chk({2'b0, rsp_lesser, rsp_greater, rsp_equal}, 5'b00010, "sign_mode");
`endif
    step(4'b0000, 1'b1, 4'b0000, "drain4");
    step(4'b0000, 1'b1, 4'b0000, "idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
